// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_pkg
// Purpose  : Default parameter constants for async_fifo and the derivation
//            of pointer / water-level width from the depth exponent.
// Contents : c_DEF_* default constants, ptr_width() helper.
// Revision : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

   localparam int c_DEF_DEPTH_WIDTH      = 10;
   localparam int c_DEF_DATA_WIDTH       = 8;
   localparam int c_DEF_ALMOST_FULL_NUM  = 1020;
   localparam int c_DEF_ALMOST_EMPTY_NUM = 4;

   // One extra bit over the address width distinguishes full from empty
   // and lets the level run from 0 to 2**depth_width inclusive.
   function automatic int ptr_width(input int depth_width);
      return depth_width + 1;
   endfunction

endpackage : async_fifo_pkg
`default_nettype wire

// File: rtl/fifo_sdpram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sdpram
// Purpose  : Simple dual-port RAM, one write port and one registered read
//            port on the same clock. Storage array is not reset; only the
//            read register is.
// Ports    : clk, rst_n          - clock, async active-low reset
//            i_wr_en/i_wr_addr/i_wr_data - write port
//            i_rd_en/i_rd_addr   - read request and address
//            o_rd_data           - registered read word, holds when idle
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sdpram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule : fifo_sdpram
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo
// Purpose  : Single-clock FIFO with registered full/empty/almost flags and
//            water level. Storage lives in fifo_sdpram.
// Ports    : clk, rst_n                       - clock, async active-low reset
//            wr_data, wr_en                   - write side
//            wr_full, wr_water_level, almost_full
//            rd_en, rd_data                   - read side
//            rd_empty, rd_water_level, almost_empty
// Config   : ASYNC_FIFO_OUTPUT_REG_EN - adds a register stage on rd_data
//            (read latency 2 instead of 1; flag timing unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int DEPTH_WIDTH      = c_DEF_DEPTH_WIDTH,
   parameter int DATA_WIDTH       = c_DEF_DATA_WIDTH,
   parameter int ALMOST_FULL_NUM  = c_DEF_ALMOST_FULL_NUM,
   parameter int ALMOST_EMPTY_NUM = c_DEF_ALMOST_EMPTY_NUM
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  wr_full,
   output logic [DEPTH_WIDTH:0]  wr_water_level,
   output logic                  almost_full,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_en,
   output logic                  rd_empty,
   output logic [DEPTH_WIDTH:0]  rd_water_level,
   output logic                  almost_empty
);

   localparam int              c_PW      = ptr_width(DEPTH_WIDTH);
   localparam logic [c_PW-1:0] c_DEPTH   = c_PW'(1) << DEPTH_WIDTH;
   localparam logic [c_PW-1:0] c_AF_NUM  = c_PW'(ALMOST_FULL_NUM);
   localparam logic [c_PW-1:0] c_AE_NUM  = c_PW'(ALMOST_EMPTY_NUM);

   logic [c_PW-1:0]       r_wr_ptr;
   logic [c_PW-1:0]       r_rd_ptr;
   logic [c_PW-1:0]       r_level;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [c_PW-1:0]       w_wr_ptr_nxt;
   logic [c_PW-1:0]       w_rd_ptr_nxt;
   logic [c_PW-1:0]       w_level_nxt;
   logic [DATA_WIDTH-1:0] w_ram_q;

   // Acceptance uses the registered (pre-edge) flags, so a write while full
   // or a read while empty never moves a pointer.
   assign w_wr_acc     = wr_en & ~r_full;
   assign w_rd_acc     = rd_en & ~r_empty;
   assign w_wr_ptr_nxt = r_wr_ptr + c_PW'(w_wr_acc);
   assign w_rd_ptr_nxt = r_rd_ptr + c_PW'(w_rd_acc);
   // Modular difference of the extended pointers is the level, wrap included.
   assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

   // Status is registered from the post-edge level so it is valid right
   // after the edge that changed the contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == c_DEPTH);
         r_empty  <= (w_level_nxt == '0);
         r_afull  <= (w_level_nxt >= c_AF_NUM);
         r_aempty <= (w_level_nxt <= c_AE_NUM);
      end
   end

   fifo_sdpram #(
      .ADDR_WIDTH (DEPTH_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr[DEPTH_WIDTH-1:0]),
      .i_wr_data (wr_data),
      .i_rd_en   (w_rd_acc),
      .i_rd_addr (r_rd_ptr[DEPTH_WIDTH-1:0]),
      .o_rd_data (w_ram_q)
   );

`ifdef ASYNC_FIFO_OUTPUT_REG_EN
   logic [DATA_WIDTH-1:0] r_rd_data_q;

   // Free-running retiming stage; the RAM register already holds between
   // reads, so loading every cycle preserves the hold behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data_q <= '0;
      end else begin
         r_rd_data_q <= w_ram_q;
      end
   end

   assign rd_data = r_rd_data_q;
`else
   assign rd_data = w_ram_q;
`endif

   assign wr_full        = r_full;
   assign rd_empty       = r_empty;
   assign almost_full    = r_afull;
   assign almost_empty   = r_aempty;
   assign wr_water_level = r_level;
   assign rd_water_level = r_level;

endmodule : async_fifo
`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo
// Purpose  : Self-checking bench for async_fifo with default parameters.
//            A queue-based reference model tracks contents; accepted reads
//            push the expected word into a scoreboard queue that a monitor
//            drains when the read data is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo;

   localparam int DW    = 10;
   localparam int DATA  = 8;
   localparam int DEPTH = 1 << DW;
   localparam int AF    = 1020;
   localparam int AE    = 4;
`ifdef ASYNC_FIFO_OUTPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DATA-1:0] wr_data;
   logic            wr_en;
   logic            wr_full;
   logic [DW:0]     wr_water_level;
   logic            almost_full;
   logic [DATA-1:0] rd_data;
   logic            rd_en;
   logic            rd_empty;
   logic [DW:0]     rd_water_level;
   logic            almost_empty;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA-1:0] mq[$];       // model contents, oldest first
   logic [DATA-1:0] exp_q[$];    // scoreboard of expected read words
   logic [1:0]      rd_pipe = '0;
   logic [DATA-1:0] last_exp = '0;

   async_fifo #(
      .DEPTH_WIDTH      (DW),
      .DATA_WIDTH       (DATA),
      .ALMOST_FULL_NUM  (AF),
      .ALMOST_EMPTY_NUM (AE)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_full        (wr_full),
      .wr_water_level (wr_water_level),
      .almost_full    (almost_full),
      .rd_data        (rd_data),
      .rd_en          (rd_en),
      .rd_empty       (rd_empty),
      .rd_water_level (rd_water_level),
      .almost_empty   (almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a word queue updated on each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         rd_pipe = '0;
      end else begin
         bit wa;
         bit ra;
         wa = wr_en && (mq.size() < DEPTH);
         ra = rd_en && (mq.size() != 0);
         if (ra) exp_q.push_back(mq.pop_front());
         if (wa) mq.push_back(wr_data);
         rd_pipe = {rd_pipe[0], ra};
      end
   end

   // Monitor: compares outputs mid-cycle against the model.
   always @(negedge clk) begin
      int lvl;
      lvl = mq.size();
      if (!rst_n) last_exp = '0;
      else if (rd_pipe[LAT-1]) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got read with no expected word at %0t", $time);
         end else begin
            last_exp = exp_q.pop_front();
         end
      end
      chk("rd_data", rd_data, last_exp);
      chk("wr_water_level", wr_water_level, lvl);
      chk("rd_water_level", rd_water_level, lvl);
      chk("wr_full", wr_full, lvl == DEPTH);
      chk("rd_empty", rd_empty, lvl == 0);
      chk("almost_full", almost_full, lvl >= AF);
      chk("almost_empty", almost_empty, lvl <= AE);
   end

   task automatic step(input bit we, input logic [DATA-1:0] d, input bit re);
      @(posedge clk);
      #2;
      wr_en   = we;
      wr_data = d;
      rd_en   = re;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_empty"}, rd_empty, 1);
      chk({tag, "_wr_full"}, wr_full, 0);
      chk({tag, "_almost_full"}, almost_full, 0);
      chk({tag, "_almost_empty"}, almost_empty, 1);
      chk({tag, "_wr_level"}, wr_water_level, 0);
      chk({tag, "_rd_level"}, rd_water_level, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("in_reset");
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) step(0, 0, 0);
      @(negedge clk);
      check_reset_outputs("idle");

      // Fill past full with a descending pattern.
      for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(255 - i), 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("fill_level", wr_water_level, DEPTH);
      chk("fill_full", wr_full, 1);

      // Drain past empty; monitor checks 0xFF,0xFE,... order.
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1);
      repeat (2) step(0, 0, 0);
      @(negedge clk);
      chk("drain_empty", rd_empty, 1);
      chk("drain_last_data", rd_data, 0);

      // Almost-empty boundary around level 4/5.
      for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("ae_at5", almost_empty, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      @(negedge clk);
      chk("ae_at4", almost_empty, 1);
      step(1, 8'($urandom), 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("ae_back5", almost_empty, 0);

      // Level 512 with simultaneous read/write.
      for (int i = 0; i < 507; i++) step(1, 8'($urandom), 0);
      for (int i = 0; i < 10; i++) step(1, 8'($urandom), 1);
      step(0, 0, 0);
      @(negedge clk);
      chk("rw_level512", rd_water_level, 512);

      // Down to 300, then reset mid-operation.
      for (int i = 0; i < 212; i++) step(0, 0, 1);
      step(0, 0, 0);
      @(negedge clk);
      chk("pre_reset_level", wr_water_level, 300);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(1, 8'hA5, 0);
      step(0, 0, 1);
      repeat (3) step(0, 0, 0);
      @(negedge clk);
      chk("post_reset_data", rd_data, 8'hA5);

      // Randomized traffic with shifting bias to reach both full and empty.
      for (int seg = 0; seg < 6; seg++) begin
         int pw;
         pw = (seg % 2 == 0) ? 85 : 15;
         for (int i = 0; i < 500; i++)
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) >= pw);
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1);
      repeat (3) step(0, 0, 0);
      @(negedge clk);
      chk("final_empty", rd_empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_async_fifo
`default_nettype wire
